// File: rtl/dcache_bypass_bridge_pkg.sv
// Shared types and encodings for the dcache bypass bridge.
// Optional build macro: DCACHE_BYPASS_WR_ACK_EN (adds the write-ack wait states).
package dcache_bypass_bridge_pkg;

`ifdef DCACHE_BYPASS_WR_ACK_EN
   typedef enum logic [2:0] {
      IDLE, P0_REQ, P0_WAIT, P1_REQ, P1_WAIT, DONE, P0_WWAIT, P1_WWAIT
   } bypass_state_t;
`else
   typedef enum logic [2:0] {
      IDLE, P0_REQ, P0_WAIT, P1_REQ, P1_WAIT, DONE
   } bypass_state_t;
`endif

   localparam logic [2:0] OP_READ      = 3'b000;
   localparam logic [2:0] OP_WRITE     = 3'b001;
   localparam int         OP_CACOP_BIT = 2;
   localparam int         OP_WE_BIT    = 0;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [2:0] TYPE_BYTE = 3'b000;
   localparam logic [2:0] TYPE_HALF = 3'b001;
   localparam logic [2:0] TYPE_WORD = 3'b010;

   // Bus transfer type is the access size with a zero top bit.
   function automatic logic [2:0] size_to_type(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return TYPE_BYTE;
         SIZE_HALF: return TYPE_HALF;
         SIZE_WORD: return TYPE_WORD;
         default:   return {1'b0, size};
      endcase
   endfunction

endpackage

// File: rtl/dcache_bypass_bridge.sv
// dcache_bypass_bridge: cacheless responder on the dcache request interface.
// Each accepted p0/p1 request is serialised into single-beat reads/writes on
// the SRAM-like bridge port; one data_ok pulse per accepted request.
// Optional build macro: DCACHE_BYPASS_WR_ACK_EN adds wr_ack and makes writes
// non-posted (wait in P0_WWAIT/P1_WWAIT for wr_ack).
//
// state    | meaning
// IDLE     | addr_ok high, waiting for p0_valid/p1_valid
// P0_REQ   | presenting port 0 access, waiting for rd_rdy/wr_rdy
// P0_WAIT  | port 0 read issued, waiting for ret_valid
// P1_REQ   | presenting port 1 access, waiting for rd_rdy/wr_rdy
// P1_WAIT  | port 1 read issued, waiting for ret_valid
// DONE     | data_ok pulse, back to IDLE next cycle
// P0_WWAIT | (ack build) port 0 write accepted, waiting for wr_ack
// P1_WWAIT | (ack build) port 1 write accepted, waiting for wr_ack
module dcache_bypass_bridge
   import dcache_bypass_bridge_pkg::*;
#(
   parameter int TAG_W    = 20,
   parameter int INDEX_W  = 8,
   parameter int OFFSET_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                p0_valid,
   input  logic                p1_valid,
   input  logic [2:0]          op,
   input  logic [TAG_W-1:0]    tag,
   input  logic [INDEX_W-1:0]  index,
   input  logic [OFFSET_W-1:0] p0_offset,
   input  logic [OFFSET_W-1:0] p1_offset,
   input  logic [3:0]          p0_wstrb,
   input  logic [3:0]          p1_wstrb,
   input  logic [31:0]         p0_wdata,
   input  logic [31:0]         p1_wdata,
   input  logic [1:0]          p0_size,
   input  logic [1:0]          p1_size,
   input  logic                uncached,
   output logic                addr_ok,
   output logic                data_ok,
   output logic [31:0]         p0_rdata,
   output logic [31:0]         p1_rdata,
   output logic                rd_req,
   output logic [2:0]          rd_type,
   output logic [31:0]         rd_addr,
   input  logic                rd_rdy,
   input  logic                ret_valid,
   input  logic                ret_last,
   input  logic [31:0]         ret_data,
   output logic                wr_req,
   output logic [2:0]          wr_type,
   output logic [31:0]         wr_addr,
   output logic [3:0]          wr_wstrb,
   output logic [31:0]         wr_data,
   input  logic                wr_rdy
`ifdef DCACHE_BYPASS_WR_ACK_EN
   ,
   input  logic                wr_ack
`endif
);

   bypass_state_t         state;
   bypass_state_t         after_p0;
   logic [2:0]            op_q;
   logic [TAG_W-1:0]      tag_q;
   logic [INDEX_W-1:0]    index_q;
   logic [OFFSET_W-1:0]   p0_offset_q, p1_offset_q;
   logic [3:0]            p0_wstrb_q, p1_wstrb_q;
   logic [31:0]           p0_wdata_q, p1_wdata_q;
   logic [1:0]            p0_size_q, p1_size_q;
   logic                  p0_valid_q, p1_valid_q;
   logic                  cur_p1, in_req, is_write, is_read;
   logic [1:0]            cur_size;
   logic                  unused_bits;

   // Bus outputs are decoded from registered state and latches only, so they
   // stay stable for as long as a request is held without rdy.
   assign cur_p1    = (state == P1_REQ);
   assign in_req    = (state == P0_REQ) || (state == P1_REQ);
   assign is_write  = (op_q[OP_WE_BIT] == OP_WRITE[OP_WE_BIT]);
   assign is_read   = (op_q[OP_WE_BIT] == OP_READ[OP_WE_BIT]);
   assign cur_size  = cur_p1 ? p1_size_q : p0_size_q;
   assign after_p0  = p1_valid_q ? P1_REQ : DONE;

   assign addr_ok   = (state == IDLE);
   assign data_ok   = (state == DONE);
   assign rd_req    = in_req && is_read;
   assign wr_req    = in_req && is_write;
   assign rd_addr   = {tag_q, index_q, cur_p1 ? p1_offset_q : p0_offset_q};
   assign rd_type   = size_to_type(cur_size);
   assign wr_addr   = rd_addr;
   assign wr_type   = rd_type;
   assign wr_wstrb  = cur_p1 ? p1_wstrb_q : p0_wstrb_q;
   assign wr_data   = cur_p1 ? p1_wdata_q : p0_wdata_q;

   // Every access goes to the bus and beats are single, so these carry no information.
   assign unused_bits = ^{uncached, ret_last, op_q[2:1], p0_valid_q};

   // Request latching, sequencing of the p0/p1 bus accesses and read-data capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         op_q        <= '0;
         tag_q       <= '0;
         index_q     <= '0;
         p0_offset_q <= '0;
         p1_offset_q <= '0;
         p0_wstrb_q  <= '0;
         p1_wstrb_q  <= '0;
         p0_wdata_q  <= '0;
         p1_wdata_q  <= '0;
         p0_size_q   <= '0;
         p1_size_q   <= '0;
         p0_valid_q  <= 1'b0;
         p1_valid_q  <= 1'b0;
         p0_rdata    <= '0;
         p1_rdata    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (p0_valid || p1_valid) begin
                  op_q        <= op;
                  tag_q       <= tag;
                  index_q     <= index;
                  p0_offset_q <= p0_offset;
                  p1_offset_q <= p1_offset;
                  p0_wstrb_q  <= p0_wstrb;
                  p1_wstrb_q  <= p1_wstrb;
                  p0_wdata_q  <= p0_wdata;
                  p1_wdata_q  <= p1_wdata;
                  p0_size_q   <= p0_size;
                  p1_size_q   <= p1_size;
                  p0_valid_q  <= p0_valid;
                  p1_valid_q  <= p1_valid;
                  if (op[OP_CACOP_BIT])
                     state <= DONE;
                  else if (p0_valid)
                     state <= P0_REQ;
                  else
                     state <= P1_REQ;
               end
            end
            P0_REQ: begin
               if (is_write) begin
                  if (wr_rdy) begin
`ifdef DCACHE_BYPASS_WR_ACK_EN
                     state <= P0_WWAIT;
`else
                     state <= after_p0;
`endif
                  end
               end else if (rd_rdy) begin
                  state <= P0_WAIT;
               end
            end
            P0_WAIT: begin
               if (ret_valid) begin
                  p0_rdata <= ret_data;
                  state    <= after_p0;
               end
            end
            P1_REQ: begin
               if (is_write) begin
                  if (wr_rdy) begin
`ifdef DCACHE_BYPASS_WR_ACK_EN
                     state <= P1_WWAIT;
`else
                     state <= DONE;
`endif
                  end
               end else if (rd_rdy) begin
                  state <= P1_WAIT;
               end
            end
            P1_WAIT: begin
               if (ret_valid) begin
                  p1_rdata <= ret_data;
                  state    <= DONE;
               end
            end
`ifdef DCACHE_BYPASS_WR_ACK_EN
            P0_WWAIT: if (wr_ack) state <= after_p0;
            P1_WWAIT: if (wr_ack) state <= DONE;
`endif
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dcache_bypass_bridge.md
Name: dcache_bypass_bridge

Overview:
- Cacheless responder for the data-side cache request interface. It accepts the dual-port (p0/p1) request bundle on the same handshake a dcache presents: valid, op, tag/index/offset, wstrb, wdata, size, addr_ok, data_ok.
- Serialises each accepted request into single-beat transactions on the SRAM-like AXI-bridge port (rd_*/wr_*/ret_*).
- Used for uncached-only builds and bring-up in place of the dcache.
- Returns one data_ok pulse per accepted request, with p0/p1 read data.

Parameters:
TAG_W, 20, tag width
INDEX_W, 8, index width
OFFSET_W, 4, offset width; TAG_W+INDEX_W+OFFSET_W must equal 32

Ports:
clk  in  1  clock
reset  in  1  reset
p0_valid  in  1  port 0 request
p1_valid  in  1  port 1 request (shares tag/index with p0)
op  in  3  {cacop, 1'b0, we}; op[2]=1 means cacop
tag  in  TAG_W  physical tag
index  in  INDEX_W  index
p0_offset / p1_offset  in  OFFSET_W  per-port offset
p0_wstrb / p1_wstrb  in  4  byte strobes
p0_wdata / p1_wdata  in  32  write data
p0_size / p1_size  in  2  0=byte, 1=half, 2=word
uncached  in  1  ignored; every access goes to the bus
addr_ok  out  1  request accepted this cycle
data_ok  out  1  one-cycle completion pulse
p0_rdata / p1_rdata  out  32  read data, valid with data_ok
rd_req  out  1  bus read request
rd_type  out  3  {1'b0, size}
rd_addr  out  32  read address
rd_rdy  in  1  read accepted
ret_valid  in  1  read data valid
ret_last  in  1  last beat; always 1 here
ret_data  in  32  read data
wr_req  out  1  bus write request
wr_type  out  3  {1'b0, size}
wr_addr  out  32  write address
wr_wstrb  out  4  write strobes
wr_data  out  32  write data
wr_rdy  in  1  write accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset. On reset: state=IDLE; all request latches cleared; addr_ok=1 (IDLE); data_ok=0; rd_req=0; wr_req=0; p0_rdata=p1_rdata=0.
- Acceptance: addr_ok=(state==IDLE), combinational. A request is accepted when addr_ok && (p0_valid || p1_valid).
- Latching on accept:
  - op, tag, index, both offsets/wstrb/wdata/sizes, p0_valid, p1_valid.
  - Address for port n = {tag, index, pn_offset}.
  - p1_valid without p0_valid is accepted and serviced as p1 only.
- FSM states: IDLE, P0_REQ, P0_WAIT, P1_REQ, P1_WAIT, DONE.
  - IDLE, accept with cacop: go to DONE; no bus activity.
  - IDLE, accept otherwise: go to P0_REQ if p0_valid, else P1_REQ.
  - Pn_REQ, read: hold rd_req=1 with address/type stable until rd_rdy, then go to Pn_WAIT.
  - Pn_REQ, write: hold wr_req=1 until wr_rdy; the write is posted, so go directly to the next port (P1_REQ if p1 is latched, else DONE).
  - Pn_WAIT: on ret_valid, capture ret_data into pn_rdata, then go to P1_REQ if n=0 and p1 is latched, else DONE.
  - DONE: data_ok=1 for exactly one cycle, then IDLE.
- data_ok timing: data_ok is never asserted in the same cycle as addr_ok. A new request can be accepted the cycle after data_ok.
- Read data:
  - p0_rdata/p1_rdata hold their value until overwritten by the next read.
  - A port with no latched request, or a write, leaves its rdata unchanged.
- Bus ordering:
  - rd_req and wr_req are never asserted together.
  - Request outputs are stable while req=1 && !rdy.
  - ret_valid outside Pn_WAIT is ignored.
  - rd_req is asserted only in REQ states, never in the same cycle it is accepted.
- Minimum latency: a single read with rd_rdy=1 and ret_valid one cycle later completes in 4 cycles from accept to data_ok.
- Reset during a transfer: the FSM returns to IDLE immediately and the in-flight transfer is abandoned. The bus slave shares the same reset.

Optional Feature:
DCACHE_BYPASS_WR_ACK_EN
- Defined: adds input wr_ack (1 bit) and states P0_WWAIT and P1_WWAIT. After wr_rdy, the FSM waits in PnWWAIT for wr_ack before advancing, so writes are non-posted. A wr_ack outside a WWAIT state is ignored.
- Undefined: writes are posted as described above. No wr_ack port exists.

Decomposition:
- Shared package:
  - State enum: bypass_state_t.
  - Size-to-rd_type constants.
  - Op encoding constants OP_READ=3'b000, OP_WRITE=3'b001, cacop flag bit 2.
- No sub-module: one FSM plus request latches.

Test Plan:
- Single read: reset, p0_valid=1, op=0, tag=20'h1c000, index=8'h12, offset=4'h4, size=2. Bus returns rd_rdy=1 and ret_data=32'hdeadbeef. Required: rd_addr=32'h1c000124, rd_type=3'b010, data_ok one cycle, p0_rdata=32'hdeadbeef, 4 cycles accept to data_ok.
- Dual read: p0_offset=4'h0, p1_offset=4'h8. Required: two rd_req in order, addresses ...120 then ...128, rets 32'h11 and 32'h22, one data_ok, p0_rdata=32'h11, p1_rdata=32'h22.
- Backpressure write: op=1, wstrb=4'b0011, wdata=32'h0000abcd, wr_rdy low for 5 cycles. Required: wr_req, wr_addr, wr_data and wr_wstrb held stable for 5 cycles, addr_ok=0 throughout, data_ok the cycle after wr_rdy.
- Cacop: op=3'b100 with p0_valid. Required: no rd_req/wr_req; data_ok exactly 1 cycle after accept.
- p1 only: p0_valid=0, p1_valid=1, p1_offset=4'hc. Required: single read to ...12c; result in p1_rdata; p0_rdata unchanged.
- Reset mid-read: assert reset in P0_WAIT, then send a stray ret_valid. Required: state IDLE, data_ok never pulses, addr_ok=1.
